mux_4x1: RTL and testbench
==========================

// Module: mux_4x1
//
// PURPOSE
// - 4-to-1 single-bit multiplexer: out = in[sel], purely combinational, zero latency.
// - Registered copies of the result and the select are provided for clocked consumers.
// - Generic selection primitive for datapath and control steering in the RISC-V core.
// - Optional saturating counter of cycles in which the selected bit is 1.
//
// PARAMETERS
// - N  default 64  width of hit_cnt; legal range 1..64.
//
// PORTS
// - clk      in   1  sole clock, rising edge.
// - rst      in   1  synchronous, active-high reset.
// - in       in   4  data inputs; in[k] is candidate k.
// - sel      in   2  select; 2'b00->in[0], 01->in[1], 10->in[2], 11->in[3].
// - out      out  1  combinational in[sel].
// - out_q    out  1  out, registered.
// - sel_q    out  2  sel, registered.
// - hit_cnt  out  N  present only with MUX_4X1_STATS_EN; saturating count.
//
// BEHAVIOUR
// - out = in[sel] combinationally, independent of clk and rst.
// - out follows any change on in or sel within the same delta, with no clock required.
// - Only the selected bit affects out. Unselected bits toggling leave out unchanged.
// - Rising edge with rst=1: out_q<=0, sel_q<=2'b00, hit_cnt<=0.
//   - rst does not gate the combinational out.
// - Rising edge with rst=0: out_q<=in[sel] and sel_q<=sel, both sampled at that edge.
//   - Latency of out_q and sel_q is exactly 1 cycle.
// - Reset mid-operation: the registers clear on the next edge.
//   - The edge after rst deasserts captures current inputs normally.
// - No handshake, no FSM; out_q and sel_q update every cycle.
// - X/Z on sel is not defined behaviour; synthesis treats sel as 2-state.
//
// CONFIGURATION
// - MUX_4X1_STATS_EN defined:
//   - hit_cnt[N-1:0] exists.
//   - Each non-reset edge where in[sel]==1, hit_cnt increments by 1.
//   - hit_cnt saturates at {N{1'b1}}; it never wraps.
//   - rst clears hit_cnt to 0 and has priority over increment.
// - MUX_4X1_STATS_EN undefined:
//   - hit_cnt port and its logic are absent.
//   - All other ports behave identically.
//
// TESTING
// - Static selection, no clock, 100 ps apart, check out each step:
//   - in=0000,sel=00 -> out=0; in=0001,sel=00 -> out=1.
//   - in=0000,sel=01 -> 0; in=0010,sel=01 -> 1.
//   - in=0000,sel=10 -> 0; in=0100,sel=10 -> 1.
//   - in=0000,sel=11 -> 0; in=1000,sel=11 -> 1.
// - Isolation:
//   - in=1110,sel=00 -> out=0.
//   - in=0111,sel=11 -> out=0.
//   - in=1011,sel=10 -> out=0.
// - Reset:
//   - rst=1 for 2 edges with in=1111,sel=11 -> out_q=0, sel_q=00, out=1.
// - Pipeline:
//   - Edge k: in=0100,sel=10; edge k+1: in=0000.
//   - After edge k: out_q=1, sel_q=10.
//   - After edge k+1: out_q=0.
// - Stats (MUX_4X1_STATS_EN, N=2):
//   - in=1111,sel=01 for 5 edges -> hit_cnt 1,2,3,3,3.
//   - Then rst -> 0.
// - Exhaustive: all 64 (in,sel) combos -> out==in[sel]; out_q matches one edge later.

Source files
------------

// File: rtl/mux_4x1_if.sv
// Signal bundle for mux_4x1: data/select inputs and the combinational and registered results.
// hit_cnt exists only when MUX_4X1_STATS_EN is defined.
interface mux_4x1_if #(
    parameter int N = 64
);
    logic [3:0] in;
    logic [1:0] sel;
    logic       out;
    logic       out_q;
    logic [1:0] sel_q;
`ifdef MUX_4X1_STATS_EN
    logic [N-1:0] hit_cnt;
`endif

    // master drives the inputs and observes results; slave is the mux itself
    modport master (
        output in,
        output sel,
        input  out,
        input  out_q,
`ifdef MUX_4X1_STATS_EN
        input  hit_cnt,
`endif
        input  sel_q
    );

    modport slave (
        input  in,
        input  sel,
        output out,
        output out_q,
`ifdef MUX_4X1_STATS_EN
        output hit_cnt,
`endif
        output sel_q
    );
endinterface

// File: rtl/mux_4x1.sv
// 4-to-1 single-bit mux with zero-latency output plus registered copies of result and select.
// Define MUX_4X1_STATS_EN to add a saturating count of cycles where the selected bit is 1.
module mux_4x1 #(
    parameter int N = 64
) (
    input logic      clk,
    input logic      rst,
    mux_4x1_if.slave bus
);
    logic sel_bit;

    assign sel_bit = bus.in[bus.sel];
    assign bus.out = sel_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_q <= 1'b0;
            bus.sel_q <= 2'b00;
        end else begin
            bus.out_q <= sel_bit;
            bus.sel_q <= bus.sel;
        end
    end

`ifdef MUX_4X1_STATS_EN
    logic [N-1:0] hit_cnt;

    // hold at all-ones instead of wrapping; reset wins over a hit on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt <= '0;
        end else if (sel_bit && (hit_cnt != {N{1'b1}})) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end

    assign bus.hit_cnt = hit_cnt;
`endif
endmodule

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1 using a queue-based scoreboard of expected results.
// Build with MUX_4X1_STATS_EN defined to also exercise the saturating hit counter (N=2).
`timescale 1ns/1ps
module tb_mux_4x1;
    localparam int N = 2;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    exp_t e;
    int   checks;
    int   errors;

    mux_4x1_if #(.N(N)) bus ();

    mux_4x1 #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic push_exp(input string name, input logic [63:0] val);
        exp_t x;
        x.name = name;
        x.val  = val;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.in  = 4'b1111;
        bus.sel = 2'b11;
        push_exp("reset_out_q", 64'd0);
        push_exp("reset_sel_q", 64'd0);
        push_exp("reset_out", 64'd1);
        repeat (2) @(posedge clk);
        #1;
        e = sb.pop_front(); checks++;
        if (bus.out_q !== e.val[0]) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b", e.name, bus.out_q, e.val[0]);
        end
        e = sb.pop_front(); checks++;
        if (bus.sel_q !== e.val[1:0]) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b", e.name, bus.sel_q, e.val[1:0]);
        end
        e = sb.pop_front(); checks++;
        if (bus.out !== e.val[0]) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b", e.name, bus.out, e.val[0]);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_static();
        logic [3:0] tin[8];
        logic [1:0] tsel[8];
        logic       texp[8];
        tin  = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
        tsel = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
        texp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            bus.in  = tin[i];
            bus.sel = tsel[i];
            push_exp($sformatf("static_%0d", i), {63'd0, texp[i]});
            #0.1;
            e = sb.pop_front(); checks++;
            if (bus.out !== e.val[0]) begin
                errors++;
                $display("[TB] FAIL %s: got %0b expected %0b", e.name, bus.out, e.val[0]);
            end
        end
    endtask

    task automatic test_isolation();
        logic [3:0] tin[3];
        logic [1:0] tsel[3];
        tin  = '{4'b1110, 4'b0111, 4'b1011};
        tsel = '{2'b00, 2'b11, 2'b10};
        for (int i = 0; i < 3; i++) begin
            bus.in  = tin[i];
            bus.sel = tsel[i];
            push_exp($sformatf("isolation_%0d", i), 64'd0);
            #0.1;
            e = sb.pop_front(); checks++;
            if (bus.out !== e.val[0]) begin
                errors++;
                $display("[TB] FAIL %s: got %0b expected %0b", e.name, bus.out, e.val[0]);
            end
        end
    endtask

    task automatic test_pipeline();
        @(negedge clk);
        bus.in  = 4'b0100;
        bus.sel = 2'b10;
        push_exp("pipe_k_out_q", 64'd1);
        push_exp("pipe_k_sel_q", 64'd2);
        @(posedge clk);
        #1;
        e = sb.pop_front(); checks++;
        if (bus.out_q !== e.val[0]) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b", e.name, bus.out_q, e.val[0]);
        end
        e = sb.pop_front(); checks++;
        if (bus.sel_q !== e.val[1:0]) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b", e.name, bus.sel_q, e.val[1:0]);
        end
        @(negedge clk);
        bus.in = 4'b0000;
        push_exp("pipe_k1_out_q", 64'd0);
        @(posedge clk);
        #1;
        e = sb.pop_front(); checks++;
        if (bus.out_q !== e.val[0]) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b", e.name, bus.out_q, e.val[0]);
        end
    endtask

`ifdef MUX_4X1_STATS_EN
    task automatic test_stats();
        logic [N-1:0] seq[5];
        seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        bus.in  = 4'b1111;
        bus.sel = 2'b01;
        for (int i = 0; i < 5; i++) begin
            push_exp($sformatf("hit_cnt_%0d", i), {62'd0, seq[i]});
            @(posedge clk);
            #1;
            e = sb.pop_front(); checks++;
            if (bus.hit_cnt !== e.val[N-1:0]) begin
                errors++;
                $display("[TB] FAIL %s: got %0d expected %0d", e.name, bus.hit_cnt, e.val[N-1:0]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        push_exp("hit_cnt_reset", 64'd0);
        @(posedge clk);
        #1;
        e = sb.pop_front(); checks++;
        if (bus.hit_cnt !== e.val[N-1:0]) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", e.name, bus.hit_cnt, e.val[N-1:0]);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    task automatic test_exhaustive();
        logic [3:0] vin;
        logic [1:0] vsel;
        for (int i = 0; i < 64; i++) begin
            vin  = i[3:0];
            vsel = i[5:4];
            @(negedge clk);
            bus.in  = vin;
            bus.sel = vsel;
            push_exp($sformatf("exh_out_%0d", i), {63'd0, vin[vsel]});
            #1;
            e = sb.pop_front(); checks++;
            if (bus.out !== e.val[0]) begin
                errors++;
                $display("[TB] FAIL %s: got %0b expected %0b", e.name, bus.out, e.val[0]);
            end
            push_exp($sformatf("exh_out_q_%0d", i), {63'd0, vin[vsel]});
            push_exp($sformatf("exh_sel_q_%0d", i), {62'd0, vsel});
            @(posedge clk);
            #1;
            e = sb.pop_front(); checks++;
            if (bus.out_q !== e.val[0]) begin
                errors++;
                $display("[TB] FAIL %s: got %0b expected %0b", e.name, bus.out_q, e.val[0]);
            end
            e = sb.pop_front(); checks++;
            if (bus.sel_q !== e.val[1:0]) begin
                errors++;
                $display("[TB] FAIL %s: got %0b expected %0b", e.name, bus.sel_q, e.val[1:0]);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.in  = 4'b0000;
        bus.sel = 2'b00;
        test_reset();
        test_static();
        test_isolation();
        test_pipeline();
`ifdef MUX_4X1_STATS_EN
        test_stats();
`endif
        test_exhaustive();
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
